shift_reg_seq: RTL and testbench
================================

Name: shift_reg_seq

Overview:
- Parametrised, command-driven successor to the plain enable-gated shift register.
- Holds one WIDTH-bit register. Accepts one command at a time over a valid/ready handshake: load, clear, hold, logical/arithmetic shift or rotate.
- Shift/rotate commands repeat for a programmable number of cycles, then pulse done.
- Includes a post-reset warm-up window during which commands are refused. This generalises the one-cycle enable-after-reset behaviour of the existing block.

Parameters:
- WIDTH, 32, register width in bits; must be >= 2.
- REP_W, 8, width of the repeat-count field.
- WARMUP, 1, number of cycles after rst deasserts before cmd_ready may assert; 0 means no warm-up.
- AMT_W, derived localparam = clog2(WIDTH), width of the shift-amount field; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command this cycle.
- cmd_mode  input  3  0 LOAD, 1 SLL, 2 SRL, 3 ROL, 4 ROR, 5 SRA, 6 HOLD, 7 CLEAR.
- cmd_amt  input  AMT_W  bits moved per step.
- cmd_rep  input  REP_W  number of steps; 0 is treated as 1.
- ser_in  input  1  fill bit for SLL/SRL.
- data_in  input  WIDTH  parallel load value.
- data_out  output  WIDTH  register contents.
- busy  output  1  command in progress (state RUN).
- done  output  1  one-cycle pulse, coincident with the final data_out value.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: data_out=0, busy=0, done=0, state=IDLE, warm-up counter=0. cmd_ready=0 while rst=1.
- Reset mid-command aborts it: no done pulse, and warm-up restarts.
- Warm-up: the counter increments each cycle with rst=0 and saturates at WARMUP. cmd_ready = (state==IDLE) && (counter==WARMUP) && !rst.
- Handshake: a command is accepted at the clock edge where cmd_valid && cmd_ready.
- At acceptance, cmd_mode, cmd_amt, ser_in, data_in and steps = max(cmd_rep,1) are latched. Inputs are ignored afterwards.
- cmd_valid while cmd_ready=0 is ignored. No queuing and no error flag.
- State machine IDLE -> RUN on acceptance.
- In RUN, one step is applied per cycle and the step counter decrements. When the last step is applied, the FSM returns to IDLE at that same edge.
- done is a registered pulse, high for exactly the cycle following the final-step edge. busy deasserts and cmd_ready reasserts in that same cycle.
- LOAD, CLEAR and HOLD always execute exactly one step and ignore cmd_rep.
- Latency: command accepted at edge 0; result visible after edge N (N = steps). The next command can be accepted at edge N+1.
- Step operations (a = latched amount, W = WIDTH):
  - LOAD: data_out <= latched data_in.
  - CLEAR: data_out <= 0.
  - HOLD: data_out unchanged.
  - SLL: shift left by a; low a bits filled with latched ser_in.
  - SRL: shift right by a; high a bits filled with latched ser_in.
  - SRA: shift right by a; filled with current MSB.
  - ROL/ROR: rotate by (a mod W).
  - a=0: value unchanged, but the step still counts.
  - a >= W (possible only for non-power-of-2 W): SLL/SRL give all-fill, SRA gives all-MSB.
- Simultaneous events: rst has priority over everything. done and a new acceptance cannot coincide, because cmd_ready is low during RUN.

Test Plan:
- WIDTH=8, WARMUP=3: deassert rst, hold cmd_valid=1 -> cmd_ready low for cycles 1-3, rises in cycle 4; first accept at that edge.
- LOAD 0xA5, then ROL amt=1 rep=3 -> busy for 3 cycles; data_out 0x4B, 0x96, 0x2D; done pulses with 0x2D, and cmd_ready rises the same cycle.
- LOAD 0x81, SRA amt=2 rep=1 -> 0xE0. SRL amt=2 ser_in=0 -> 0x38. SLL amt=3 ser_in=1 -> 0xC7.
- rep=0 with ROR amt=4 on 0x12 -> single step, 0x21, done after 1 cycle. HOLD with rep=200 -> one step, done next cycle, value unchanged.
- Assert rst during step 2 of a rep=5 SLL -> data_out=0, busy=0, no done pulse; warm-up restarts; a new command is accepted only after WARMUP cycles.
- Toggle cmd_valid and change data_in while busy -> no effect on data_out, and the command is not accepted until cmd_ready=1.

Source files
------------

// File: rtl/shift_reg_seq.sv
// rtl/shift_reg_seq.sv - command-driven shift/rotate register with repeat count and post-reset warm-up
//
// Purpose: holds one WIDTH-bit register. Commands (load, clear, hold, logical/arithmetic
// shift, rotate) arrive over a valid/ready handshake. Shift and rotate commands repeat for
// a programmable number of steps and then pulse done. cmd_ready stays low for WARMUP
// cycles after reset is released.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   cmd_valid  in   command present
//   cmd_ready  out  command accepted at this edge when cmd_valid is also high
//   cmd_mode   in   0 LOAD, 1 SLL, 2 SRL, 3 ROL, 4 ROR, 5 SRA, 6 HOLD, 7 CLEAR
//   cmd_amt    in   bits moved per step
//   cmd_rep    in   number of steps (0 treated as 1)
//   ser_in     in   fill bit for SLL/SRL
//   data_in    in   parallel load value
//   data_out   out  register contents
//   busy       out  command in progress
//   done       out  one-cycle pulse with the final data_out value
module shift_reg_seq #(
    parameter int WIDTH  = 32,
    parameter int REP_W  = 8,
    parameter int WARMUP = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [2:0]                   cmd_mode,
    input  logic [$clog2(WIDTH)-1:0]     cmd_amt,
    input  logic [REP_W-1:0]             cmd_rep,
    input  logic                         ser_in,
    input  logic [WIDTH-1:0]             data_in,
    output logic [WIDTH-1:0]             data_out,
    output logic                         busy,
    output logic                         done
);

    localparam int AMT_W = $clog2(WIDTH);
    localparam int WU_W  = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

    localparam logic [2:0] M_LOAD  = 3'd0;
    localparam logic [2:0] M_SLL   = 3'd1;
    localparam logic [2:0] M_SRL   = 3'd2;
    localparam logic [2:0] M_ROL   = 3'd3;
    localparam logic [2:0] M_ROR   = 3'd4;
    localparam logic [2:0] M_SRA   = 3'd5;
    localparam logic [2:0] M_HOLD  = 3'd6;
    localparam logic [2:0] M_CLEAR = 3'd7;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [WU_W-1:0]    r_wu;
    logic [REP_W-1:0]   r_steps;
    logic [2:0]         r_mode;
    logic [AMT_W-1:0]   r_amt;
    logic               r_ser;
    logic [WIDTH-1:0]   r_din;
    logic [WIDTH-1:0]   r_data;
    logic               r_busy;
    logic               r_done;

    logic               w_accept;
    logic               w_single;
    logic [WIDTH-1:0]   w_next;

    assign cmd_ready = (r_state == IDLE) && (r_wu == WU_W'(WARMUP)) && !rst;
    assign w_accept  = cmd_valid && cmd_ready;

    // LOAD/CLEAR/HOLD are one-shot regardless of the repeat field; rep=0 also means one step.
    assign w_single  = (cmd_mode == M_LOAD) || (cmd_mode == M_CLEAR) ||
                       (cmd_mode == M_HOLD) || (cmd_rep == '0);

    // One step of the latched operation applied to the current register value.
    // Shift amounts >= WIDTH shift everything out, which yields all-fill / all-MSB naturally.
    always_comb begin
        int unsigned      rot;
        logic [WIDTH-1:0] ones;
        w_next = r_data;
        ones   = '1;
        rot    = int'(r_amt) % WIDTH;
        unique case (r_mode)
            M_LOAD:  w_next = r_din;
            M_CLEAR: w_next = '0;
            M_HOLD:  w_next = r_data;
            M_SLL:   w_next = (r_data << r_amt) | (r_ser ? ~(ones << r_amt) : '0);
            M_SRL:   w_next = (r_data >> r_amt) | (r_ser ? ~(ones >> r_amt) : '0);
            M_SRA:   w_next = $signed(r_data) >>> r_amt;
            M_ROL:   w_next = (r_data << rot) | (r_data >> (WIDTH - rot));
            M_ROR:   w_next = (r_data >> rot) | (r_data << (WIDTH - rot));
            default: w_next = r_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_wu    <= '0;
            r_steps <= '0;
            r_mode  <= M_HOLD;
            r_amt   <= '0;
            r_ser   <= 1'b0;
            r_din   <= '0;
            r_data  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_wu != WU_W'(WARMUP)) begin
                r_wu <= r_wu + 1'b1;
            end
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_mode  <= cmd_mode;
                        r_amt   <= cmd_amt;
                        r_ser   <= ser_in;
                        r_din   <= data_in;
                        r_steps <= w_single ? REP_W'(1) : cmd_rep;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_data <= w_next;
                    if (r_steps == REP_W'(1)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_steps <= r_steps - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign data_out = r_data;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_shift_reg_seq.sv
// tb/tb_shift_reg_seq.sv - directed self-checking bench for shift_reg_seq (WIDTH=8, WARMUP=3)
module tb_shift_reg_seq;

    localparam int WIDTH  = 8;
    localparam int REP_W  = 8;
    localparam int WARMUP = 3;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_mode;
    logic [2:0]       cmd_amt;
    logic [REP_W-1:0] cmd_rep;
    logic             ser_in;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             busy;
    logic             done;

    int n_total = 0;
    int n_bad   = 0;

    shift_reg_seq #(.WIDTH(WIDTH), .REP_W(REP_W), .WARMUP(WARMUP)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_amt   (cmd_amt),
        .cmd_rep   (cmd_rep),
        .ser_in    (ser_in),
        .data_in   (data_in),
        .data_out  (data_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for cmd_ready, present one command for exactly one accepting edge.
    task automatic send(input logic [2:0] m, input logic [2:0] a, input logic [7:0] rep,
                        input logic s, input logic [7:0] d);
        int n;
        n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        chk("send_ready", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_mode  = m;
        cmd_amt   = a;
        cmd_rep   = rep;
        ser_in    = s;
        data_in   = d;
        tick();
        cmd_valid = 1'b0;
        chk("accept_busy", {31'd0, busy}, 32'd1);
    endtask

    // After acceptance: step through the run checking data each cycle, done on the last.
    task automatic expect_run(input string tag, input int steps, input logic [7:0] fin);
        for (int i = 1; i < steps; i++) begin
            tick();
            chk({tag, "_mid_done"}, {31'd0, done}, 32'd0);
        end
        tick();
        chk({tag, "_data"}, {24'd0, data_out}, {24'd0, fin});
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_mode  = 3'd0;
        cmd_amt   = 3'd0;
        cmd_rep   = 8'd0;
        ser_in    = 1'b0;
        data_in   = 8'd0;
        tick();
        tick();
        chk("rst_data", {24'd0, data_out}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd0);

        // Warm-up: ready low in cycles 1..3 after release, high in cycle 4.
        rst       = 1'b0;
        cmd_valid = 1'b1;
        cmd_mode  = 3'd0;
        data_in   = 8'hA5;
        for (int c = 1; c <= 3; c++) begin
            #1;
            chk("warm_ready_low", {31'd0, cmd_ready}, 32'd0);
            tick();
        end
        chk("warm_ready_high", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
        chk("warm_accept_busy", {31'd0, busy}, 32'd1);
        expect_run("load_a5", 1, 8'hA5);

        // ROL 1 x3: 4B, 96, 2D
        send(3'd3, 3'd1, 8'd3, 1'b0, 8'h00);
        tick();
        chk("rol_s1", {24'd0, data_out}, 32'h4B);
        chk("rol_s1_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("rol_s2", {24'd0, data_out}, 32'h96);
        chk("rol_s2_ready", {31'd0, cmd_ready}, 32'd0);
        tick();
        chk("rol_s3", {24'd0, data_out}, 32'h2D);
        chk("rol_done", {31'd0, done}, 32'd1);
        chk("rol_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        chk("done_pulse_clear", {31'd0, done}, 32'd0);

        send(3'd0, 3'd0, 8'd0, 1'b0, 8'h81);
        expect_run("load_81", 1, 8'h81);
        send(3'd5, 3'd2, 8'd1, 1'b0, 8'h00);
        expect_run("sra", 1, 8'hE0);
        send(3'd2, 3'd2, 8'd1, 1'b0, 8'h00);
        expect_run("srl", 1, 8'h38);
        send(3'd1, 3'd3, 8'd1, 1'b1, 8'h00);
        expect_run("sll", 1, 8'hC7);

        send(3'd0, 3'd0, 8'd0, 1'b0, 8'h12);
        expect_run("load_12", 1, 8'h12);
        send(3'd4, 3'd4, 8'd0, 1'b0, 8'h00);
        expect_run("ror_rep0", 1, 8'h21);
        send(3'd6, 3'd0, 8'd200, 1'b0, 8'hFF);
        expect_run("hold", 1, 8'h21);
        send(3'd3, 3'd0, 8'd2, 1'b0, 8'h00);
        expect_run("rol_amt0", 2, 8'h21);
        send(3'd7, 3'd0, 8'd9, 1'b0, 8'h00);
        expect_run("clear", 1, 8'h00);

        // Reset during step 2 of a rep=5 SLL.
        send(3'd1, 3'd1, 8'd5, 1'b1, 8'h00);
        tick();
        chk("abort_s1", {24'd0, data_out}, 32'h01);
        rst = 1'b1;
        tick();
        chk("abort_data", {24'd0, data_out}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_ready", {31'd0, cmd_ready}, 32'd0);
        rst       = 1'b0;
        cmd_valid = 1'b1;
        cmd_mode  = 3'd0;
        data_in   = 8'h5A;
        for (int c = 1; c <= 3; c++) begin
            #1;
            chk("rewarm_ready_low", {31'd0, cmd_ready}, 32'd0);
            chk("rewarm_no_done", {31'd0, done}, 32'd0);
            tick();
        end
        chk("rewarm_ready_high", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
        expect_run("load_5a", 1, 8'h5A);

        // Inputs wiggling while busy must not disturb the run: ROL 2 x4 on 5A.
        send(3'd3, 3'd2, 8'd4, 1'b0, 8'h00);
        cmd_mode = 3'd0;
        data_in  = 8'hFF;
        cmd_valid = 1'b1;
        tick();
        chk("busy_s1", {24'd0, data_out}, 32'h69);
        chk("busy_s1_ready", {31'd0, cmd_ready}, 32'd0);
        cmd_valid = 1'b0;
        tick();
        chk("busy_s2", {24'd0, data_out}, 32'hA5);
        cmd_valid = 1'b1;
        tick();
        chk("busy_s3", {24'd0, data_out}, 32'h96);
        tick();
        chk("busy_s4", {24'd0, data_out}, 32'h5A);
        chk("busy_done", {31'd0, done}, 32'd1);
        chk("busy_ready", {31'd0, cmd_ready}, 32'd1);
        // The still-pending LOAD FF is taken only now that ready is high.
        tick();
        cmd_valid = 1'b0;
        chk("late_accept_busy", {31'd0, busy}, 32'd1);
        expect_run("late_load", 1, 8'hFF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
